// File: rtl/s64x7_pkg.sv
// Shared constants for the s64x7 stack-machine core: opcodes, function codes,
// reset vector and the byte-lane helpers used by loads and stores.
package s64x7_pkg;

  localparam logic [63:0] RESET_PC_DEF = 64'hE000_0000_0000_0000;

  localparam logic [3:0] OPC_NEXT   = 4'd0;
  localparam logic [3:0] OPC_LIT8   = 4'd1;
  localparam logic [3:0] OPC_LIT16  = 4'd2;
  localparam logic [3:0] OPC_LIT32  = 4'd3;
  localparam logic [3:0] OPC_STORES = 4'd4;
  localparam logic [3:0] OPC_LOADS  = 4'd5;
  localparam logic [3:0] OPC_INTOPS = 4'd6;

  localparam logic [3:0] FN_SBM = 4'd0;
  localparam logic [3:0] FN_SHM = 4'd1;
  localparam logic [3:0] FN_SWM = 4'd2;
  localparam logic [3:0] FN_SDM = 4'd3;

  localparam logic [3:0] FN_LBMS = 4'd0;
  localparam logic [3:0] FN_LHMS = 4'd1;
  localparam logic [3:0] FN_LWMS = 4'd2;
  localparam logic [3:0] FN_LDMS = 4'd3;
  localparam logic [3:0] FN_LBMU = 4'd4;
  localparam logic [3:0] FN_LHMU = 4'd5;
  localparam logic [3:0] FN_LWMU = 4'd6;
  localparam logic [3:0] FN_LDMU = 4'd7;

  localparam logic [3:0] FN_ADD  = 4'd0;
  localparam logic [3:0] FN_SLL  = 4'd1;
  localparam logic [3:0] FN_SLT  = 4'd2;
  localparam logic [3:0] FN_SLTU = 4'd3;
  localparam logic [3:0] FN_XOR  = 4'd4;
  localparam logic [3:0] FN_SRL  = 4'd5;
  localparam logic [3:0] FN_OR   = 4'd6;
  localparam logic [3:0] FN_AND  = 4'd7;
  localparam logic [3:0] FN_SUB  = 4'd8;
  localparam logic [3:0] FN_SRA  = 4'd13;

  // Byte offset of an access: address bits below the access size are dropped.
  function automatic logic [2:0] lane_off(input logic [1:0] size, input logic [2:0] a);
    case (size)
      2'd0:    lane_off = a;
      2'd1:    lane_off = {a[2:1], 1'b0};
      2'd2:    lane_off = {a[2], 2'b00};
      default: lane_off = 3'd0;
    endcase
  endfunction

  function automatic logic [7:0] lane_sel(input logic [1:0] size, input logic [2:0] a);
    logic [7:0] m;
    case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    lane_sel = m << lane_off(size, a);
  endfunction

endpackage

// File: rtl/s64x7_alu.sv
// Combinational integer unit for INTOPS: result = a op b, a = NOS, b = TOS.
module s64x7_alu import s64x7_pkg::*; (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [3:0]  fn,
  output logic [63:0] result
);

  logic [5:0] shamt;
  assign shamt = b[5:0];

  always_comb begin
    result = '0;
    case (fn)
      FN_ADD:  result = a + b;
      FN_SLL:  result = a << shamt;
      FN_SLT:  result = {63'd0, $signed(a) < $signed(b)};
      FN_SLTU: result = {63'd0, a < b};
      FN_XOR:  result = a ^ b;
      FN_SRL:  result = a >> shamt;
      FN_OR:   result = a | b;
      FN_AND:  result = a & b;
      FN_SUB:  result = a - b;
      FN_SRA:  result = $signed(a) >>> shamt;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/s64x7.sv
// s64x7 core: packet fetch, opcode/literal shift registers, circular data stack
// and a single bus master port shared by fetch, load and store.
module s64x7 import s64x7_pkg::*; #(
  parameter logic [63:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        ack_i,
  input  logic [63:0] dat_i,
  output logic [63:3] adr_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic [7:0]  sel_o,
  output logic        we_o,
  output logic        vpa_o,
  output logic [3:0]  opc_o,
  output logic [63:0] dat_o
);

  // Bus handshake: a cycle is requested while cyc_o=stb_o=1 and every output
  // holds until a rising edge samples ack_i=1, which completes it.

  // DEPTH must be a power of two so the pointer wraps the stack naturally.
  localparam int SPW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [63:0]    pc_q;
  logic [59:0]    opr_q;
  logic [63:0]    lit_q;
  logic [63:0]    stk_q [DEPTH];
  logic [SPW-1:0] sp_q;

  logic [SPW-1:0] sp_up, sp_dn;
  logic [63:0]    tos, nos;
  logic [3:0]     opc, fn;
  logic [1:0]     size;
  logic [2:0]     off;
  logic [63:0]    st_data, ld_shift, ld_data, push_val, alu_res;

  assign sp_up = sp_q + SPW'(1);
  assign sp_dn = sp_q - SPW'(1);
  assign tos   = stk_q[sp_q];
  assign nos   = stk_q[sp_dn];
  assign opc   = opr_q[59:56];
  assign fn    = lit_q[3:0];
  // Loads and stores size on fn[1:0]; fn[3] is ignored for both.
  assign size  = fn[1:0];
  assign off   = lane_off(size, tos[2:0]);

  s64x7_alu u_alu (
    .a      (nos),
    .b      (tos),
    .fn     (fn),
    .result (alu_res)
  );

  always_comb begin
    st_data = nos;
    case (size)
      FN_SBM[1:0]: st_data = {8{nos[7:0]}};
      FN_SHM[1:0]: st_data = {4{nos[15:0]}};
      FN_SWM[1:0]: st_data = {2{nos[31:0]}};
      default:     st_data = nos;
    endcase
  end

  assign ld_shift = dat_i >> {off, 3'b000};

  always_comb begin
    ld_data = ld_shift;
    case (size)
      2'd0: ld_data = fn[2] ? {56'd0, ld_shift[7:0]}  : {{56{ld_shift[7]}},  ld_shift[7:0]};
      2'd1: ld_data = fn[2] ? {48'd0, ld_shift[15:0]} : {{48{ld_shift[15]}}, ld_shift[15:0]};
      2'd2: ld_data = fn[2] ? {32'd0, ld_shift[31:0]} : {{32{ld_shift[31]}}, ld_shift[31:0]};
      default: ld_data = ld_shift;
    endcase
  end

  always_comb begin
    push_val = '0;
    case (opc)
      OPC_LIT8:  push_val = {56'd0, lit_q[7:0]};
      OPC_LIT16: push_val = {48'd0, lit_q[15:0]};
      OPC_LIT32: push_val = {32'd0, lit_q[31:0]};
      default:   push_val = '0;
    endcase
  end

  always_comb begin
    cyc_o = 1'b0;
    adr_o = '0;
    sel_o = '0;
    we_o  = 1'b0;
    vpa_o = 1'b0;
    dat_o = '0;
    case (opc)
      OPC_NEXT: begin
        cyc_o = 1'b1;
        vpa_o = 1'b1;
        sel_o = 8'hFF;
        adr_o = pc_q[63:3];
      end
      OPC_STORES: begin
        cyc_o = 1'b1;
        we_o  = 1'b1;
        sel_o = lane_sel(size, tos[2:0]);
        adr_o = tos[63:3];
        dat_o = st_data;
      end
      OPC_LOADS: begin
        cyc_o = 1'b1;
        sel_o = lane_sel(size, tos[2:0]);
        adr_o = tos[63:3];
      end
      default: ;
    endcase
  end

  assign stb_o = cyc_o;
  assign opc_o = opc;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      pc_q  <= RESET_PC;
      opr_q <= '0;
      lit_q <= '0;
      sp_q  <= '0;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
    end else begin
      case (opc)
        OPC_NEXT: begin
          if (ack_i) begin
            opr_q <= dat_i[59:0];
            lit_q <= dat_i;
            pc_q  <= pc_q + 64'd8;
          end
        end
        OPC_LIT8: begin
          sp_q         <= sp_up;
          stk_q[sp_up] <= push_val;
          lit_q        <= lit_q >> 8;
          opr_q        <= {opr_q[55:0], 4'h0};
        end
        OPC_LIT16: begin
          sp_q         <= sp_up;
          stk_q[sp_up] <= push_val;
          lit_q        <= lit_q >> 16;
          opr_q        <= {opr_q[55:0], 4'h0};
        end
        OPC_LIT32: begin
          sp_q         <= sp_up;
          stk_q[sp_up] <= push_val;
          lit_q        <= lit_q >> 32;
          opr_q        <= {opr_q[55:0], 4'h0};
        end
        OPC_STORES: begin
          if (ack_i) begin
            sp_q  <= sp_q - SPW'(2);
            lit_q <= lit_q >> 4;
            opr_q <= {opr_q[55:0], 4'h0};
          end
        end
        OPC_LOADS: begin
          if (ack_i) begin
            stk_q[sp_q] <= ld_data;
            lit_q       <= lit_q >> 4;
            opr_q       <= {opr_q[55:0], 4'h0};
          end
        end
        OPC_INTOPS: begin
          stk_q[sp_dn] <= alu_res;
          sp_q         <= sp_dn;
          lit_q        <= lit_q >> 4;
          opr_q        <= {opr_q[55:0], 4'h0};
        end
        default: opr_q <= {opr_q[55:0], 4'h0};
      endcase
    end
  end

endmodule

// File: tb/tb_s64x7.sv
// Self-checking bench for s64x7: directed packet scenarios plus a randomized
// run compared cycle by cycle against an instruction-level reference model.
module tb_s64x7;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        ack_i = 1'b0;
  logic [63:0] dat_i = '0;
  logic [63:3] adr_o;
  logic        cyc_o, stb_o, we_o, vpa_o;
  logic [7:0]  sel_o;
  logic [3:0]  opc_o;
  logic [63:0] dat_o;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_pc;

  localparam logic [63:0] RST_PC = 64'hE000_0000_0000_0000;
  localparam logic [63:0] JUNK   = 64'hA5A5_5A5A_C3C3_3C3C;

  s64x7 dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .ack_i   (ack_i),
    .dat_i   (dat_i),
    .adr_o   (adr_o),
    .cyc_o   (cyc_o),
    .stb_o   (stb_o),
    .sel_o   (sel_o),
    .we_o    (we_o),
    .vpa_o   (vpa_o),
    .opc_o   (opc_o),
    .dat_o   (dat_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // Drive bus inputs for one cycle; outputs are then sampled 1 unit after the edge.
  task automatic step(input logic ack, input logic [63:0] d);
    ack_i = ack;
    dat_i = d;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    step(1'b1, 64'h0);
    step(1'b1, 64'h0);
    exp_pc = RST_PC;
    checks++; if (adr_o !== exp_pc[63:3]) begin failures++; $display("FAIL reset_adr got=%h exp=%h", adr_o, exp_pc[63:3]); end
    checks++; if ({cyc_o, stb_o, vpa_o, we_o} !== 4'b1110) begin failures++; $display("FAIL reset_ctl got=%b exp=1110", {cyc_o, stb_o, vpa_o, we_o}); end
    checks++; if (sel_o !== 8'hFF) begin failures++; $display("FAIL reset_sel got=%h exp=ff", sel_o); end
    checks++; if (opc_o !== 4'd0 || dat_o !== 64'd0) begin failures++; $display("FAIL reset_opc_dat got=%h/%h exp=0/0", opc_o, dat_o); end
    reset_i = 1'b1;
    step(1'b1, 64'h0);
    exp_pc = exp_pc + 64'd8;
    checks++; if (adr_o !== exp_pc[63:3] || vpa_o !== 1'b1) begin failures++; $display("FAIL reset_next_fetch got=%h exp=%h", adr_o, exp_pc[63:3]); end
  endtask

  task automatic test_stores();
    logic [31:0] addr;
    logic [7:0]  esel;
    logic [63:0] edat, a64;
    for (int s = 0; s < 3; s++) begin
      case (s)
        0:       begin addr = 32'h1111_1111; esel = 8'h02; edat = 64'h4141_4141_4141_4141; end
        1:       begin addr = 32'h2222_2220; esel = 8'h03; edat = 64'h0041_0041_0041_0041; end
        default: begin addr = 32'h3333_3334; esel = 8'hF0; edat = 64'h0000_0041_0000_0041; end
      endcase
      a64 = {32'h0, addr};
      step(1'b1, {4'h4, 16'h1340, 4'(s), addr, 8'h41});
      exp_pc = exp_pc + 64'd8;
      checks++; if (opc_o !== 4'd1) begin failures++; $display("FAIL store_opc1 s=%0d got=%h exp=1", s, opc_o); end
      step(1'b1, JUNK);
      checks++; if (opc_o !== 4'd3) begin failures++; $display("FAIL store_opc3 s=%0d got=%h exp=3", s, opc_o); end
      step(1'b1, JUNK);
      checks++; if (opc_o !== 4'd4 || we_o !== 1'b1 || vpa_o !== 1'b0) begin failures++; $display("FAIL store_ctl s=%0d got=%h/%b/%b exp=4/1/0", s, opc_o, we_o, vpa_o); end
      checks++; if (sel_o !== esel) begin failures++; $display("FAIL store_sel s=%0d got=%h exp=%h", s, sel_o, esel); end
      checks++; if (dat_o !== edat) begin failures++; $display("FAIL store_dat s=%0d got=%h exp=%h", s, dat_o, edat); end
      checks++; if (adr_o !== a64[63:3]) begin failures++; $display("FAIL store_adr s=%0d got=%h exp=%h", s, adr_o, a64[63:3]); end
      step(1'b1, JUNK);
      checks++; if (opc_o !== 4'd0 || adr_o !== exp_pc[63:3] || vpa_o !== 1'b1) begin failures++; $display("FAIL store_then_fetch s=%0d got=%h exp=%h", s, adr_o, exp_pc[63:3]); end
    end
  endtask

  task automatic test_loads();
    logic [3:0]  fn;
    logic [31:0] addr;
    logic [63:0] din, eval, a64, st64;
    logic [7:0]  esel;
    st64 = 64'h1111_1110;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       begin fn = 4'd4; addr = 32'h5555_5555; din = 64'h0000_8100_0000_0000; esel = 8'h20; eval = 64'h0000_0000_0000_0081; end
        1:       begin fn = 4'd0; addr = 32'h5555_5555; din = 64'h0000_8100_0000_0000; esel = 8'h20; eval = 64'hFFFF_FFFF_FFFF_FF81; end
        default: begin fn = 4'd1; addr = 32'h5555_5552; din = 64'h0000_0000_8100_0000; esel = 8'h0C; eval = 64'hFFFF_FFFF_FFFF_8100; end
      endcase
      a64 = {32'h0, addr};
      step(1'b1, {4'h3, 4'h3, 4'h5, 16'h0, fn, addr});
      exp_pc = exp_pc + 64'd8;
      step(1'b1, JUNK);
      checks++; if (opc_o !== 4'd5 || we_o !== 1'b0 || sel_o !== esel) begin failures++; $display("FAIL load_bus k=%0d got=%h/%b/%h exp=5/0/%h", k, opc_o, we_o, sel_o, esel); end
      checks++; if (adr_o !== a64[63:3]) begin failures++; $display("FAIL load_adr k=%0d got=%h exp=%h", k, adr_o, a64[63:3]); end
      step(1'b1, din);
      checks++; if (opc_o !== 4'd0 || adr_o !== exp_pc[63:3]) begin failures++; $display("FAIL load_then_fetch k=%0d got=%h exp=%h", k, adr_o, exp_pc[63:3]); end
      step(1'b1, 64'h3340_0003_1111_1110);
      exp_pc = exp_pc + 64'd8;
      step(1'b1, JUNK);
      checks++; if (opc_o !== 4'd4 || sel_o !== 8'hFF || adr_o !== st64[63:3]) begin failures++; $display("FAIL load_store_bus k=%0d got=%h/%h/%h", k, opc_o, sel_o, adr_o); end
      checks++; if (dat_o !== eval) begin failures++; $display("FAIL load_value k=%0d got=%h exp=%h", k, dat_o, eval); end
      step(1'b1, JUNK);
    end
  endtask

  task automatic test_intops();
    logic [3:0]  fn;
    logic [63:0] eres;
    logic [3:0]  eop;
    for (int k = 0; k < 11; k++) begin
      case (k)
        0:  begin fn = 4'd0;  eres = 64'h13; end
        1:  begin fn = 4'd8;  eres = 64'h0F; end
        2:  begin fn = 4'd1;  eres = 64'h44; end
        3:  begin fn = 4'd2;  eres = 64'h00; end
        4:  begin fn = 4'd3;  eres = 64'h00; end
        5:  begin fn = 4'd4;  eres = 64'h13; end
        6:  begin fn = 4'd5;  eres = 64'h04; end
        7:  begin fn = 4'd13; eres = 64'h04; end
        8:  begin fn = 4'd6;  eres = 64'h13; end
        9:  begin fn = 4'd7;  eres = 64'h00; end
        default: begin fn = 4'd9; eres = 64'h00; end
      endcase
      step(1'b1, {4'h6, 16'h1161, 4'h4, 8'h00, 4'h3, 8'h00, fn, 16'h0211});
      exp_pc = exp_pc + 64'd8;
      for (int c = 0; c < 4; c++) begin
        case (c)
          0, 1:    eop = 4'd1;
          2:       eop = 4'd6;
          default: eop = 4'd1;
        endcase
        checks++; if (opc_o !== eop) begin failures++; $display("FAIL intop_seq fn=%0d c=%0d got=%h exp=%h", fn, c, opc_o, eop); end
        step(1'b1, JUNK);
      end
      checks++; if (opc_o !== 4'd4 || adr_o !== 61'd0 || sel_o !== 8'hFF) begin failures++; $display("FAIL intop_store fn=%0d got=%h/%h/%h", fn, opc_o, adr_o, sel_o); end
      checks++; if (dat_o !== eres) begin failures++; $display("FAIL intop_result fn=%0d got=%h exp=%h", fn, dat_o, eres); end
      step(1'b1, JUNK);
    end
  endtask

  task automatic test_wait_states();
    logic [63:0] a64;
    a64 = 64'h3333_3334;
    for (int c = 0; c < 3; c++) begin
      step(1'b0, JUNK);
      checks++; if (opc_o !== 4'd0 || adr_o !== exp_pc[63:3] || vpa_o !== 1'b1) begin failures++; $display("FAIL wait_fetch c=%0d got=%h exp=%h", c, adr_o, exp_pc[63:3]); end
    end
    step(1'b1, {4'h4, 16'h1340, 4'h2, 32'h3333_3334, 8'h41});
    exp_pc = exp_pc + 64'd8;
    step(1'b1, JUNK);
    step(1'b1, JUNK);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (opc_o !== 4'd4 || sel_o !== 8'hF0 || dat_o !== 64'h0000_0041_0000_0041 || adr_o !== a64[63:3] || we_o !== 1'b1) begin
        failures++; $display("FAIL wait_store c=%0d got=%h/%h/%h/%h", c, opc_o, sel_o, dat_o, adr_o);
      end
      step(c == 3, JUNK);
    end
    checks++; if (opc_o !== 4'd0 || adr_o !== exp_pc[63:3]) begin failures++; $display("FAIL wait_after_fetch got=%h exp=%h", adr_o, exp_pc[63:3]); end
  endtask

  task automatic test_reset_mid_op();
    step(1'b1, {4'h0, 16'h1115, 16'h0000, 4'h4, 24'h56_3412});
    exp_pc = exp_pc + 64'd8;
    step(1'b1, JUNK);
    step(1'b1, JUNK);
    step(1'b1, JUNK);
    checks++; if (opc_o !== 4'd5 || sel_o !== 8'h40) begin failures++; $display("FAIL mid_load_pending got=%h/%h exp=5/40", opc_o, sel_o); end
    step(1'b0, JUNK);
    #2;
    reset_i = 1'b0;
    #1;
    exp_pc = RST_PC;
    checks++; if (opc_o !== 4'd0 || adr_o !== exp_pc[63:3] || vpa_o !== 1'b1 || we_o !== 1'b0 || sel_o !== 8'hFF) begin
      failures++; $display("FAIL mid_reset_fetch got=%h/%h/%b exp=0/%h/1", opc_o, adr_o, vpa_o, exp_pc[63:3]);
    end
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    step(1'b1, {4'h0, 4'h1, 4'h4, 40'h0, 4'h3, 8'h08});
    exp_pc = exp_pc + 64'd8;
    step(1'b1, JUNK);
    checks++; if (opc_o !== 4'd4 || adr_o !== 61'd1) begin failures++; $display("FAIL mid_post_store got=%h/%h exp=4/1", opc_o, adr_o); end
    checks++; if (dat_o !== 64'd0) begin failures++; $display("FAIL mid_stack_cleared got=%h exp=0", dat_o); end
    step(1'b1, JUNK);
    checks++; if (adr_o !== exp_pc[63:3]) begin failures++; $display("FAIL mid_next_fetch got=%h exp=%h", adr_o, exp_pc[63:3]); end
  endtask

  function automatic logic [63:0] alu_ref(input int fn, input logic [63:0] a, input logic [63:0] b);
    int sh;
    sh = int'(b[5:0]);
    case (fn)
      0:  return a + b;
      1:  return a << sh;
      2:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      3:  return (a < b) ? 64'd1 : 64'd0;
      4:  return a ^ b;
      5:  return a >> sh;
      6:  return a | b;
      7:  return a & b;
      8:  return a - b;
      13: return $signed(a) >>> sh;
      default: return 64'd0;
    endcase
  endfunction

  task automatic test_random(input int ncyc);
    logic [63:0]  m_pc, m_lit, t, n, din, edat, v, mask;
    logic [63:0]  m_stk [8];
    int           m_ops[$];
    int           m_sp, eopc, fn, sz, off, w;
    logic         ack, ecyc, ewe, evpa;
    logic [7:0]   esel;
    logic [63:3]  eadr;
    logic [140:0] got, expv;
    reset_i = 1'b0;
    step(1'b0, 64'h0);
    reset_i = 1'b1;
    m_pc = RST_PC;
    m_lit = '0;
    m_sp = 0;
    for (int i = 0; i < 8; i++) m_stk[i] = '0;
    m_ops.delete();
    for (int c = 0; c < ncyc; c++) begin
      eopc = (m_ops.size() > 0) ? m_ops[0] : 0;
      t = m_stk[m_sp];
      n = m_stk[(m_sp + 7) % 8];
      fn = int'(m_lit[3:0]);
      sz = 1 << (fn % 4);
      off = (int'(t[2:0]) / sz) * sz;
      ecyc = 1'b0; ewe = 1'b0; evpa = 1'b0; esel = '0; eadr = '0; edat = '0;
      if (eopc == 0) begin
        ecyc = 1'b1; evpa = 1'b1; esel = 8'hFF; eadr = m_pc[63:3];
      end else if (eopc == 4 || eopc == 5) begin
        ecyc = 1'b1;
        ewe = (eopc == 4);
        esel = 8'(((1 << sz) - 1) << off);
        eadr = t[63:3];
        if (eopc == 4)
          for (int b = 0; b < 8; b++) edat[b*8 +: 8] = n[(b % sz)*8 +: 8];
      end
      got  = {opc_o, cyc_o, stb_o, vpa_o, we_o, sel_o, adr_o, dat_o};
      expv = {4'(eopc), ecyc, ecyc, evpa, ewe, esel, eadr, edat};
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL random_cycle c=%0d got=%h exp=%h", c, got, expv);
      end
      ack = ($urandom_range(0, 3) != 0);
      din = {$urandom(), $urandom()};
      step(ack, din);
      case (eopc)
        0: if (ack) begin
          m_ops.delete();
          for (int i = 14; i >= 0; i--) m_ops.push_back(int'(din[i*4 +: 4]));
          m_lit = din;
          m_pc = m_pc + 64'd8;
        end
        1, 2, 3: begin
          w = (eopc == 1) ? 8 : (eopc == 2) ? 16 : 32;
          m_sp = (m_sp + 1) % 8;
          m_stk[m_sp] = m_lit & ((64'd1 << w) - 64'd1);
          m_lit = m_lit >> w;
          void'(m_ops.pop_front());
        end
        4: if (ack) begin
          m_sp = (m_sp + 6) % 8;
          m_lit = m_lit >> 4;
          void'(m_ops.pop_front());
        end
        5: if (ack) begin
          v = din >> (off * 8);
          if (sz < 8) begin
            mask = (64'd1 << (sz * 8)) - 64'd1;
            v = v & mask;
            if ((fn & 4) == 0 && v[sz*8-1]) v = v | ~mask;
          end
          m_stk[m_sp] = v;
          m_lit = m_lit >> 4;
          void'(m_ops.pop_front());
        end
        6: begin
          v = alu_ref(fn, n, t);
          m_sp = (m_sp + 7) % 8;
          m_stk[m_sp] = v;
          m_lit = m_lit >> 4;
          void'(m_ops.pop_front());
        end
        default: void'(m_ops.pop_front());
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_stores();
    test_loads();
    test_intops();
    test_wait_states();
    test_reset_mid_op();
    test_random(3000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
